// File: rtl/four_bit_encoder_if.sv
// four_bit_encoder_if: request lines, capture enable and the code/VALID/ACK handshake of the encoder.
interface four_bit_encoder_if;
    logic EN;
    logic I0;
    logic I1;
    logic I2;
    logic I3;
    logic ACK;
    logic Q0;
    logic Q1;
    logic VALID;
    logic OVF;

    modport master (
        output EN, I0, I1, I2, I3, ACK,
        input  Q0, Q1, VALID, OVF
    );

    modport slave (
        input  EN, I0, I1, I2, I3, ACK,
        output Q0, Q1, VALID, OVF
    );
endinterface

// File: rtl/four_bit_encoder.sv
// four_bit_encoder: captures request rising edges as pending bits and presents one index at a time under VALID/ACK.
module four_bit_encoder #(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic CLK,
    input  logic nRST,
    four_bit_encoder_if.slave bus
);
    typedef enum logic {IDLE, PRESENT} state_t;

    state_t     state_q, state_d;
    logic [3:0] prev_q, pend_q, pend_d;
    logic [3:0] req, edges, acc_mask;
    logic [1:0] code_q, code_d, win;
    logic       ovf_q, ovf_d, accept;

    always_comb begin
        req      = {bus.I3, bus.I2, bus.I1, bus.I0};
        edges    = req & ~prev_q & {4{bus.EN}};
        accept   = (state_q == PRESENT) && bus.ACK;
        acc_mask = accept ? (4'b0001 << code_q) : 4'b0000;
        // an edge on the index being accepted re-arms it rather than overflowing
        pend_d   = (pend_q & ~acc_mask) | edges;
        ovf_d    = |(edges & pend_q & ~acc_mask);
    end

    always_comb begin
        win = 2'd0;
        if (LOW_FIRST) begin
            for (int n = 3; n >= 0; n--)
                if (pend_q[n]) win = 2'(n);
        end else begin
            for (int n = 0; n < 4; n++)
                if (pend_q[n]) win = 2'(n);
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            IDLE: if (|pend_q) begin
                code_d  = win;
                state_d = PRESENT;
            end
            PRESENT: if (bus.ACK) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            prev_q  <= 4'b0000;
            pend_q  <= 4'b0000;
            code_q  <= 2'b00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= req;
            pend_q  <= pend_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.VALID = state_q == PRESENT;
    assign bus.Q1    = code_q[1];
    assign bus.Q0    = code_q[0];
    assign bus.OVF   = ovf_q;
endmodule

// File: tb/tb_four_bit_encoder.sv
// tb_four_bit_encoder: drives a low-first and a high-first encoder with directed and random requests against a set-based model.
module tb_four_bit_encoder;
    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       en = 1'b0;
    logic       ack = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;

    // model state per instance: 0 = lowest index first, 1 = highest index first
    bit pending [2][4];
    bit last_in [4];
    bit showing [2];
    int shown   [2];
    bit lost    [2];

    always #5 CLK = ~CLK;

    four_bit_encoder_if bl ();
    four_bit_encoder_if bh ();

    assign bl.EN = en;  assign bh.EN = en;
    assign bl.ACK = ack; assign bh.ACK = ack;
    assign bl.I0 = req[0]; assign bl.I1 = req[1]; assign bl.I2 = req[2]; assign bl.I3 = req[3];
    assign bh.I0 = req[0]; assign bh.I1 = req[1]; assign bh.I2 = req[2]; assign bh.I3 = req[3];

    four_bit_encoder #(.LOW_FIRST(1'b1)) dut_l (.CLK(CLK), .nRST(nRST), .bus(bl.slave));
    four_bit_encoder #(.LOW_FIRST(1'b0)) dut_h (.CLK(CLK), .nRST(nRST), .bus(bh.slave));

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            showing[k] = 0;
            shown[k]   = 0;
            lost[k]    = 0;
            for (int n = 0; n < 4; n++) pending[k][n] = 0;
        end
        for (int n = 0; n < 4; n++) last_in[n] = 0;
    endfunction

    function automatic int pick(input int k);
        int best = -1;
        for (int n = 0; n < 4; n++)
            if (pending[k][n] && (best < 0 || k == 1)) best = n;
        return best;
    endfunction

    function automatic void model_step(input logic [3:0] r, input logic e, input logic a);
        for (int k = 0; k < 2; k++) begin
            int taken = (showing[k] && a) ? shown[k] : -1;
            int nxt   = pick(k);
            lost[k] = 0;
            for (int n = 0; n < 4; n++)
                if (r[n] && !last_in[n] && e && pending[k][n] && n != taken) lost[k] = 1;
            if (showing[k]) begin
                if (a) showing[k] = 0;
            end else if (nxt >= 0) begin
                showing[k] = 1;
                shown[k]   = nxt;
            end
            if (taken >= 0) pending[k][taken] = 0;
            for (int n = 0; n < 4; n++)
                if (r[n] && !last_in[n] && e) pending[k][n] = 1;
        end
        for (int n = 0; n < 4; n++) last_in[n] = r[n];
    endfunction

    task automatic compare();
        check("valid_lo", int'(bl.VALID), int'(showing[0]));
        check("code_lo",  int'({bl.Q1, bl.Q0}), shown[0]);
        check("ovf_lo",   int'(bl.OVF), int'(lost[0]));
        check("valid_hi", int'(bh.VALID), int'(showing[1]));
        check("code_hi",  int'({bh.Q1, bh.Q0}), shown[1]);
        check("ovf_hi",   int'(bh.OVF), int'(lost[1]));
    endtask

    task automatic tick(input logic [3:0] r, input logic e, input logic a);
        req = r;
        en  = e;
        ack = a;
        @(posedge CLK);
        model_step(r, e, a);
        #1;
        compare();
    endtask

    initial begin
        model_reset();
        req = 4'b1111;
        #2;
        check("rst_valid", int'(bl.VALID), 0);
        check("rst_ovf",   int'(bl.OVF), 0);
        check("rst_code",  int'({bl.Q1, bl.Q0}), 0);
        nRST = 1'b1;
        tick(4'b1111, 1, 0);
        check("rst_first_idle", int'(bl.VALID), 0);
        tick(4'b1111, 1, 0);
        check("rst_first_valid", int'(bl.VALID), 1);
        check("rst_first_code_lo", int'({bl.Q1, bl.Q0}), 0);
        check("rst_first_code_hi", int'({bh.Q1, bh.Q0}), 3);
        for (int i = 0; i < 10; i++) tick(4'b0000, 1, 1);
        // single request on I2 with ACK held
        tick(4'b0100, 1, 1);
        tick(4'b0000, 1, 1);
        check("single_valid", int'(bl.VALID), 1);
        check("single_code", int'({bl.Q1, bl.Q0}), 2);
        tick(4'b0000, 1, 1);
        check("single_drop", int'(bl.VALID), 0);
        for (int i = 0; i < 3; i++) tick(4'b0000, 1, 1);
        // I3 and I1 together
        tick(4'b1010, 1, 1);
        for (int i = 0; i < 6; i++) tick(4'b0000, 1, 1);
        // two I0 pulses without ACK, then accept
        tick(4'b0001, 1, 0);
        tick(4'b0000, 1, 0);
        tick(4'b0001, 1, 0);
        check("ovf_pulse", int'(bl.OVF), 1);
        tick(4'b0000, 1, 0);
        check("ovf_once", int'(bl.OVF), 0);
        for (int i = 0; i < 5; i++) tick(4'b0000, 1, 1);
        // re-raise I1 while code 01 is being accepted
        tick(4'b0010, 1, 0);
        tick(4'b0000, 1, 0);
        tick(4'b0000, 1, 0);
        tick(4'b0010, 1, 1);
        check("set_wins_no_ovf", int'(bl.OVF), 0);
        for (int i = 0; i < 5; i++) tick(4'b0000, 1, 1);
        // disabled capture, then stall on code 00 while I1 pulses
        tick(4'b1000, 0, 0);
        for (int i = 0; i < 3; i++) tick(4'b0000, 0, 0);
        check("en_blocks", int'(bl.VALID), 0);
        tick(4'b0001, 1, 0);
        tick(4'b0000, 1, 0);
        for (int i = 0; i < 5; i++) tick((i == 1) ? 4'b0010 : 4'b0000, 1, 0);
        check("stall_code", int'({bl.Q1, bl.Q0}), 0);
        for (int i = 0; i < 6; i++) tick(4'b0000, 1, 1);
        // reset in the middle of a handshake
        tick(4'b0110, 1, 0);
        tick(4'b0000, 1, 0);
        nRST = 1'b0;
        #1;
        check("mid_rst_valid_lo", int'(bl.VALID), 0);
        check("mid_rst_valid_hi", int'(bh.VALID), 0);
        model_reset();
        nRST = 1'b1;
        for (int i = 0; i < 4; i++) tick(4'b0000, 1, 1);
        for (int i = 0; i < 3000; i++)
            tick(4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                 $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/four_bit_encoder.md
# four_bit_encoder

Registered 4-to-2 request encoder: the inverse of the enabled 2-to-4 decoder on the same bus. It captures rising edges on four one-hot request lines, queues them as pending bits, and presents the index of one pending request as a binary code (Q1 Q0) under a VALID/ACK handshake. It sits in front of a 2-to-4 decoder: a consumer driving that decoder with the presented code reproduces the originating line.

## Interface
- LOW_FIRST, 1, priority order: 1 means the lowest pending index wins (I0 highest priority); 0 means the highest index wins (I3 highest priority).
- CLK  input  1  clock; all state changes on rising edge.
- nRST  input  1  asynchronous, active-low reset; one clock domain only.
- EN  input  1  capture enable; when low, new edges are ignored.
- I0, I1, I2, I3  input  1 each  request lines, synchronous to CLK, level signals; a request is a 0->1 transition.
- ACK  input  1  consumer accepts the presented code.
- Q0, Q1  output  1 each  presented index, Q1 = MSB (I2 -> Q1=1, Q0=0).
- VALID  output  1  Q1/Q0 hold a pending index.
- OVF  output  1  one-cycle pulse: a request was lost.

## Operation
- Edge detect: PREV[3:0] registers I3..I0 every cycle. EDGE[n] = In & ~PREV[n] & EN.
- PEND[3:0] register: PEND[n] is set by EDGE[n] and cleared by acceptance of index n (VALID & ACK & code==n). If set and clear happen in the same cycle, set wins.
- OVF pulses for one cycle when EDGE[n] arrives while PEND[n]=1 and index n is not being accepted in the same cycle. PEND is unchanged.
- The state machine has two states:
  - IDLE: VALID=0. If PEND != 0, load Q1/Q0 with the winner chosen by LOW_FIRST and go to PRESENT. The winner is taken from the registered PEND, not from the EDGE of the current cycle.
  - PRESENT: VALID=1. Q1/Q0 hold stable. If ACK=1, clear PEND[code] and go to IDLE.
- There is no preemption. A higher-priority arrival during PRESENT waits until after the acceptance.
- EN=0 only blocks capture. Pending requests and the handshake continue normally.
- ACK while VALID=0 is ignored.

## Timing
- Reset (nRST low, asynchronous): PREV=0, PEND=0, state=IDLE, Q0=Q1=0, VALID=0, OVF=0.
- Because PREV resets to 0, a line held high when nRST releases counts as an edge at the first sampling edge if EN=1.
- Latency: an edge sampled at clock k sets PEND after k. VALID rises after clock k+1, so a request is presented 2 cycles after the input rises.
- Acceptance at clock m, when VALID=1 and ACK=1:
  - VALID falls after m.
  - The next presentation has VALID rising after m+1 at the earliest.
  - Back-to-back accepted codes are therefore spaced 2 cycles apart.
- Q0/Q1 change only on entry to PRESENT. In IDLE they keep the last presented code.
- OVF is registered and asserts the cycle after the lost edge is sampled.
- Reset asserted mid-handshake drops VALID immediately and discards all pending requests.

## Test plan
- **Reset:** nRST=0 with I3..I0=1111. Required: VALID=0, OVF=0, Q=00. Release nRST with EN=1 and ACK=0. Required: PEND=1111 after the first edge, VALID=1 with Q1Q0=00 one cycle later (LOW_FIRST=1).
- **Single request:** pulse I2 for one cycle with EN=1, ACK held 1. Required: VALID=1 with Q1Q0=10 exactly 2 cycles after the pulse, for one cycle, then VALID=0 with PEND=0.
- **Priority:** raise I3 and I1 in the same cycle, ACK=1. Required with LOW_FIRST=1: codes 01 then 11, spaced 2 cycles apart. Repeat with LOW_FIRST=0. Required: codes 11 then 01.
- **Overflow:** pulse I0 twice with ACK=0. Required: one OVF pulse, the cycle after the second edge. After ACK, the code 00 is presented once only.
- **Set wins over clear:** raise I1 in the same cycle that code 01 is accepted. Required: no OVF, and code 01 is presented again 2 cycles later.
- **Enable and stall:** with EN=0, pulse I3. Required: VALID stays 0. Then, with EN=1, present code 00 and hold ACK=0 for 5 cycles while pulsing I1. Required: Q stays 00, VALID stays 1, and code 01 follows the eventual acceptance.
